// File: rtl/exp5_pkg.sv
// +----------------------------------------------------------------------+
// | exp5_pkg : state codes and widths shared by the game control unit.   |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

package exp5_pkg;

    localparam int STATE_W = 4;

    // Codes are fixed because db_estado feeds the HEX5 display directly.
    typedef enum logic [STATE_W-1:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARACAO  = 4'h1,
        ST_ESPERA      = 4'h2,
        ST_REGISTRA    = 4'h4,
        ST_COMPARACAO  = 4'h5,
        ST_PROXIMO     = 4'h6,
        ST_FIM_ACERTO  = 4'hA,
        ST_FIM_TIMEOUT = 4'hD,
        ST_FIM_ERRO    = 4'hE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/contador_timeout.sv
// +----------------------------------------------------------------------+
// | contador_timeout : saturating move-timeout counter; fim flags the    |
// | last allowed cycle (count == TIMEOUT_CYCLES-1).                      |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at the last value instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            r_count <= '0;
        end else if (conta && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign fim = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/exp5_unidade_controle.sv
// +----------------------------------------------------------------------+
// | exp5_unidade_controle : Moore FSM sequencing the game datapath.      |
// | Build macro UC_TIMEOUT_EN enables the move timeout and fim_timeout.  |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module exp5_unidade_controle
    import exp5_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               jogada,
    input  logic               igual,
    input  logic               fimC,
    output logic               zeraC,
    output logic               contaC,
    output logic               zeraR,
    output logic               registraR,
    output logic               pronto,
    output logic               acertou,
    output logic               errou,
    output logic               timeout,
    output logic [STATE_W-1:0] db_estado
);

    state_t r_state;
    state_t w_next_state;
    logic   w_timer_fim;

    // Configurations below the legal minimum of 2 generate nothing extra.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_below_min
    end

`ifdef UC_TIMEOUT_EN
    logic w_timer_zera;
    logic w_timer_conta;

    assign w_timer_zera  = (r_state == ST_PREPARACAO) || (r_state == ST_REGISTRA) ||
                           (r_state == ST_PROXIMO);
    assign w_timer_conta = (r_state == ST_ESPERA);

    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (w_timer_zera),
        .conta (w_timer_conta),
        .fim   (w_timer_fim)
    );
`else
    assign w_timer_fim = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_INICIAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        zeraC        = 1'b0;
        contaC       = 1'b0;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        pronto       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        timeout      = 1'b0;
        case (r_state)
            ST_INICIAL: begin
                if (iniciar) w_next_state = ST_PREPARACAO;
            end
            ST_PREPARACAO: begin
                zeraC        = 1'b1;
                zeraR        = 1'b1;
                w_next_state = ST_ESPERA;
            end
            ST_ESPERA: begin
                // A move on the last allowed cycle beats the timeout.
                if (jogada)           w_next_state = ST_REGISTRA;
                else if (w_timer_fim) w_next_state = ST_FIM_TIMEOUT;
            end
            ST_REGISTRA: begin
                registraR    = 1'b1;
                w_next_state = ST_COMPARACAO;
            end
            ST_COMPARACAO: begin
                if (!igual)    w_next_state = ST_FIM_ERRO;
                else if (fimC) w_next_state = ST_FIM_ACERTO;
                else           w_next_state = ST_PROXIMO;
            end
            ST_PROXIMO: begin
                contaC       = 1'b1;
                w_next_state = ST_ESPERA;
            end
            ST_FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) w_next_state = ST_PREPARACAO;
            end
            ST_FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) w_next_state = ST_PREPARACAO;
            end
`ifdef UC_TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar) w_next_state = ST_PREPARACAO;
            end
`endif
            default: begin
                w_next_state = ST_INICIAL;
            end
        endcase
    end

    assign db_estado = r_state;

endmodule

`default_nettype wire

// File: tb/tb_exp5_unidade_controle.sv
// +----------------------------------------------------------------------+
// | tb_exp5_unidade_controle : directed self-checking bench for the game |
// | control FSM (TIMEOUT_CYCLES = 5).                                    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_exp5_unidade_controle;

    localparam int C_TIMEOUT = 5;

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    localparam logic [7:0] C_O_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_O_PREP  = 8'b1010_0000;
    localparam logic [7:0] C_O_REG   = 8'b0001_0000;
    localparam logic [7:0] C_O_PROX  = 8'b0100_0000;
    localparam logic [7:0] C_O_ACER  = 8'b0000_1100;
    localparam logic [7:0] C_O_ERRO  = 8'b0000_1010;
    localparam logic [7:0] C_O_TOUT  = 8'b0000_1001;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_conta      = 0;

    exp5_unidade_controle #(
        .TIMEOUT_CYCLES (C_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (contaC) n_conta <= n_conta + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [7:0] outs);
        chk(tag, {20'd0, db_estado, zeraC, contaC, zeraR, registraR,
                  pronto, acertou, errou, timeout}, {20'd0, st, outs});
    endtask

    // One move from espera: registra, comparacao, then the decision state.
    task automatic move(input string tag, input logic eq, input logic last,
                        input logic [3:0] st_end, input logic [7:0] o_end);
        jogada = 1'b1; igual = eq; fimC = last;
        step();
        jogada = 1'b0;
        chk_st({tag, "_reg"}, 4'h4, C_O_REG);
        step();
        chk_st({tag, "_cmp"}, 4'h5, C_O_NONE);
        step();
        chk_st({tag, "_end"}, st_end, o_end);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b1; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
        step();
        chk_st("reset", 4'h0, C_O_NONE);
        reset = 1'b0;
        step();
        chk_st("prep", 4'h1, C_O_PREP);
        iniciar = 1'b0;
        step();
        chk_st("espera0", 4'h2, C_O_NONE);

        // Full success over four addresses
        n_conta = 0;
        for (int i = 0; i < 3; i++) begin
            move("ok", 1'b1, 1'b0, 4'h6, C_O_PROX);
            step();
            chk_st("ok_back", 4'h2, C_O_NONE);
        end
        move("ok4", 1'b1, 1'b1, 4'hA, C_O_ACER);
        chk("conta_pulses", n_conta, 3);

        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk_st("jogada_ignored", 4'hA, C_O_ACER);

        // Error on the second move
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_st("restart1", 4'h1, C_O_PREP);
        step();
        move("e1", 1'b1, 1'b0, 4'h6, C_O_PROX);
        step();
        move("e2", 1'b0, 1'b0, 4'hE, C_O_ERRO);
        step();
        chk_st("erro_hold", 4'hE, C_O_ERRO);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_st("restart2", 4'h1, C_O_PREP);
        step();
        chk_st("restart2_esp", 4'h2, C_O_NONE);

`ifdef UC_TIMEOUT_EN
        // Currently in espera cycle 1 of 5
        repeat (C_TIMEOUT - 1) step();
        chk_st("tout_cycle5", 4'h2, C_O_NONE);
        step();
        chk_st("tout", 4'hD, C_O_TOUT);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_st("restart3", 4'h1, C_O_PREP);
        step();
        repeat (C_TIMEOUT - 1) step();
        chk_st("last_cycle", 4'h2, C_O_NONE);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk_st("jogada_wins", 4'h4, C_O_REG);
`else
        repeat (50) step();
        chk_st("no_timeout", 4'h2, C_O_NONE);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk_st("late_jogada", 4'h4, C_O_REG);
`endif

        step();
        chk_st("mid_cmp", 4'h5, C_O_NONE);
        reset = 1'b1; igual = 1'b1; fimC = 1'b1;
        step();
        chk_st("mid_reset", 4'h0, C_O_NONE);
        reset = 1'b0;
        step();
        chk_st("idle_hold", 4'h0, C_O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
